data_mem: RTL and testbench

//   Byte-addressed data memory for the single-cycle RISC-V core, serving LB/LH/LW/LBU/LHU/SB/SH/SW.

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem_ld_ext.sv | 34 +++
 rtl/data_mem.sv | 112 +++++++++++
 tb/tb_data_mem.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory: bus width, access size codes, I/O address.
package data_mem_pkg;

  localparam int          BUS_WIDTH   = 32;
  localparam int          DEPTH_BYTES = 256;
  localparam logic [31:0] IO_ADDR     = 32'h100;

  // 2'b11 is decoded as a full word everywhere
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10,
    WORD_ALT  = 2'b11
  } mem_size_e;

endpackage

// File: rtl/data_mem_ld_ext.sv
// Load extender: picks the byte/half lane out of a raw little-endian word and sign/zero-extends it.
// Purely combinational, zero latency, no backpressure.
module d_mem_ld_ext (
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sz_ex_i,
  output logic [31:0] rd_data_o
);
  import data_mem_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    unique case (off_i)
      2'd0: byte_sel = raw_i[7:0];
      2'd1: byte_sel = raw_i[15:8];
      2'd2: byte_sel = raw_i[23:16];
      2'd3: byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];

    rd_data_o = raw_i;
    unique case (mem_size_e'(size_i))
      BYTE:      rd_data_o = {{24{sz_ex_i & byte_sel[7]}}, byte_sel};
      HALF_WORD: rd_data_o = {{16{sz_ex_i & half_sel[15]}}, half_sel};
      default:   rd_data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory with combinational little-endian loads and rising-edge stores; optional
// memory-mapped I/O word at IO_ADDR enabled by MEM_MAP_IO_EN. Zero-latency reads, no backpressure.
module data_mem #(
  parameter int          BUS_WIDTH   = data_mem_pkg::BUS_WIDTH,
  parameter int          DEPTH_BYTES = data_mem_pkg::DEPTH_BYTES,
  parameter logic [31:0] IO_ADDR     = data_mem_pkg::IO_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] d_mem_address,
  input  logic [BUS_WIDTH-1:0] d_mem_wr_data,
  input  logic                 d_mem_wr_en,
  input  logic [1:0]           d_mem_size,
  input  logic                 d_mem_sz_ex,
  output logic [BUS_WIDTH-1:0] d_mem_rd_data,
  output logic [BUS_WIDTH-1:0] mem_map_io
);
  import data_mem_pkg::*;

  localparam int                   AW      = $clog2(DEPTH_BYTES);
  localparam logic [BUS_WIDTH-1:0] DEPTH_W = BUS_WIDTH'(DEPTH_BYTES);
`ifdef MEM_MAP_IO_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic [7:0]           mem_q [DEPTH_BYTES];
  logic [BUS_WIDTH-1:0] word_addr;
  logic                 in_ram;
  logic                 is_io;
  logic                 ram_we;
  logic [3:0]           lane_en;
  logic [31:0]          lane_dat;
  logic [31:0]          ram_word;
  logic [31:0]          raw_word;
  logic [31:0]          io_q;

  // Every access is resolved against its containing word; lane_en picks the bytes inside it.
  assign word_addr = {d_mem_address[BUS_WIDTH-1:2], 2'b00};
  assign is_io     = IO_EN && (word_addr == IO_ADDR);
  assign in_ram    = (word_addr < DEPTH_W) && !is_io;
  assign ram_we    = d_mem_wr_en && in_ram;

  always_comb begin
    lane_en  = 4'b1111;
    lane_dat = d_mem_wr_data;
    unique case (mem_size_e'(d_mem_size))
      BYTE: begin
        lane_en  = 4'b0001 << d_mem_address[1:0];
        lane_dat = {4{d_mem_wr_data[7:0]}};
      end
      HALF_WORD: begin
        lane_en  = d_mem_address[1] ? 4'b1100 : 4'b0011;
        lane_dat = {2{d_mem_wr_data[15:0]}};
      end
      default: begin
        lane_en  = 4'b1111;
        lane_dat = d_mem_wr_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
    end else if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_q[{word_addr[AW-1:2], 2'(i)}] <= lane_dat[8*i +: 8];
      end
    end
  end

  always_comb begin
    ram_word = '0;
    for (int i = 0; i < 4; i++) ram_word[8*i +: 8] = mem_q[{word_addr[AW-1:2], 2'(i)}];
  end

`ifdef MEM_MAP_IO_EN
  logic [31:0] io_d;

  always_comb begin
    io_d = io_q;
    if (d_mem_wr_en && is_io) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) io_d[8*i +: 8] = lane_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) io_q <= '0;
    else     io_q <= io_d;
  end
`else
  assign io_q = '0;
`endif

  // Unmapped addresses feed zero into the extender, which keeps it zero.
  assign raw_word = is_io ? io_q : (in_ram ? ram_word : 32'h0);

  d_mem_ld_ext u_ld_ext (
    .raw_i     (raw_word),
    .off_i     (d_mem_address[1:0]),
    .size_i    (d_mem_size),
    .sz_ex_i   (d_mem_sz_ex),
    .rd_data_o (d_mem_rd_data)
  );

  assign mem_map_io = io_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; I/O expectations follow MEM_MAP_IO_EN.
module tb_data_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdat;
  logic        we;
  logic [1:0]  size;
  logic        sx;
  logic [31:0] rd;
  logic [31:0] io;

  int vectors    = 0;
  int miscompares = 0;

`ifdef MEM_MAP_IO_EN
  localparam bit IO_ON = 1'b1;
`else
  localparam bit IO_ON = 1'b0;
`endif

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  data_mem dut (
    .clk           (clk),
    .rst           (rst),
    .d_mem_address (addr),
    .d_mem_wr_data (wdat),
    .d_mem_wr_en   (we),
    .d_mem_size    (size),
    .d_mem_sz_ex   (sx),
    .d_mem_rd_data (rd),
    .mem_map_io    (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(negedge clk);
    addr = a; wdat = d; size = s; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] s,
                    input logic x, input logic [31:0] exp);
    addr = a; size = s; sx = x;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdat = '0; we = 1'b0; size = SZ_W; sx = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk("rst_io", io, 32'h0);
    ld("rst_lw0", 32'd0, SZ_W, 1'b0, 32'h0);
    ld("rst_lw4", 32'd4, SZ_W, 1'b0, 32'h0);
    ld("rst_lw8", 32'd8, SZ_W, 1'b0, 32'h0);

    // byte store, signed and unsigned byte loads
    st(32'd0, 32'h0000_00FF, SZ_B);
    ld("lb0", 32'd0, SZ_B, 1'b1, 32'hFFFF_FFFF);
    ld("lbu0", 32'd0, SZ_B, 1'b0, 32'h0000_00FF);

    // byte store only writes the low byte
    st(32'd4, 32'h0000_FFFF, SZ_B);
    ld("lhu4", 32'd4, SZ_H, 1'b0, 32'h0000_00FF);

    // word store, lanes read back individually
    st(32'd8, 32'h00FF_FFFF, SZ_W);
    ld("lw8", 32'd8, SZ_W, 1'b0, 32'h00FF_FFFF);
    ld("lb10", 32'd10, SZ_B, 1'b1, 32'hFFFF_FFFF);
    ld("lb11", 32'd11, SZ_B, 1'b1, 32'h0000_0000);
    ld("lw9_align", 32'd9, SZ_W, 1'b0, 32'h00FF_FFFF);
    ld("lw_sz11", 32'd8, 2'b11, 1'b1, 32'h00FF_FFFF);

    // half store at odd address aligns down; lane masking
    st(32'd13, 32'h1234_ABCD, SZ_H);
    ld("lh12", 32'd12, SZ_H, 1'b1, 32'hFFFF_ABCD);
    ld("lhu14", 32'd14, SZ_H, 1'b0, 32'h0000_0000);
    st(32'd15, 32'h0000_0080, SZ_B);
    ld("lw12", 32'd12, SZ_W, 1'b0, 32'h8000_ABCD);
    ld("lh14", 32'd14, SZ_H, 1'b1, 32'hFFFF_8000);

    // top RAM byte
    st(32'd255, 32'h0000_005A, SZ_B);
    ld("lbu255", 32'd255, SZ_B, 1'b0, 32'h0000_005A);
    ld("lw252", 32'd252, SZ_W, 1'b0, 32'h5A00_0000);

    // read-during-write: old value until the edge, new after
    @(negedge clk);
    addr = 32'd8; size = SZ_W; sx = 1'b0; wdat = 32'hDEAD_BEEF; we = 1'b1;
    #1;
    chk("rdw_before", rd, 32'h00FF_FFFF);
    @(posedge clk);
    #1;
    chk("rdw_after", rd, 32'hDEAD_BEEF);
    we = 1'b0;

    // wr_en low: no change
    @(negedge clk);
    addr = 32'd8; size = SZ_W; wdat = 32'h1111_1111; we = 1'b0;
    @(posedge clk);
    #1;
    ld("noen_lw8", 32'd8, SZ_W, 1'b0, 32'hDEAD_BEEF);

    // memory-mapped I/O word
    st(32'h100, 32'hFFFF_FFFF, SZ_W);
    chk("io_sw", io, IO_ON ? 32'hFFFF_FFFF : 32'h0);
    ld("io_lw", 32'h100, SZ_W, 1'b0, IO_ON ? 32'hFFFF_FFFF : 32'h0);
    st(32'h102, 32'h0000_0000, SZ_B);
    chk("io_sb", io, IO_ON ? 32'hFF00_FFFF : 32'h0);
    ld("io_lhu", 32'h102, SZ_H, 1'b0, IO_ON ? 32'h0000_FF00 : 32'h0);
    ld("io_lh", 32'h102, SZ_H, 1'b1, IO_ON ? 32'hFFFF_FF00 : 32'h0);
    ld("io_lb", 32'h103, SZ_B, 1'b1, IO_ON ? 32'hFFFF_FFFF : 32'h0);
    ld("ram_lw0", 32'd0, SZ_W, 1'b0, 32'h0000_00FF);
    ld("ram_lw4", 32'd4, SZ_W, 1'b0, 32'h0000_00FF);
    ld("ram_lw8", 32'd8, SZ_W, 1'b0, 32'hDEAD_BEEF);

    // out-of-range store ignored, load zero, no aliasing into RAM
    st(32'd300, 32'h1234_5678, SZ_W);
    chk("oor_io", io, IO_ON ? 32'hFF00_FFFF : 32'h0);
    ld("oor_lw", 32'd300, SZ_W, 1'b0, 32'h0);
    ld("oor_alias44", 32'd44, SZ_W, 1'b0, 32'h0);
    ld("oor_lw0", 32'd0, SZ_W, 1'b0, 32'h0000_00FF);

    // reset mid-stream clears everything and blocks a concurrent store
    @(negedge clk);
    rst = 1'b1; addr = 32'd16; wdat = 32'h1111_1111; size = SZ_W; we = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0;
    chk("rst2_io", io, 32'h0);
    ld("rst2_lw16", 32'd16, SZ_W, 1'b0, 32'h0);
    ld("rst2_lw8", 32'd8, SZ_W, 1'b0, 32'h0);
    ld("rst2_lw252", 32'd252, SZ_W, 1'b0, 32'h0);
    ld("rst2_lw0", 32'd0, SZ_W, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
